// File: rtl/ciclo_rtc_multimodo.sv
// Purpose : period/phase sequencer; splits time into TICKS-clock periods and
//           steps a phase index ciclo through 0..duracion-1, continuous or one-shot.
// Latency : outputs registered; activo and cuenta_int=0 one edge after EN_ciclo
//           is seen in IDLE, and first fin_ciclo TICKS edges after that entry.
// Backpressure: none. EN_ciclo=0 returns to IDLE on the next edge. With
//           CICLO_RTC_PAUSA_EN defined, pausa freezes counting while in RUN.
//
// Ports:
//   clk, reset (sync, active-high), EN_ciclo (run enable), modo (0 wrap / 1 one-shot),
//   duracion (phases per sequence, 0 acts as 1), pausa (only with CICLO_RTC_PAUSA_EN),
//   ciclo (phase index), cuenta_int (tick counter), fin_ciclo / fin_total (pulses),
//   activo (high while in RUN).
// Optional feature macro: CICLO_RTC_PAUSA_EN
module ciclo_rtc_multimodo #(
  parameter int CYCLE_W = 6,
  parameter int TICK_W  = 5,
  parameter int TICKS   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               EN_ciclo,
  input  logic               modo,
  input  logic [CYCLE_W-1:0] duracion,
`ifdef CICLO_RTC_PAUSA_EN
  input  logic               pausa,
`endif
  output logic [CYCLE_W-1:0] ciclo,
  output logic [TICK_W-1:0]  cuenta_int,
  output logic               fin_ciclo,
  output logic               fin_total,
  output logic               activo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);

  state_t             state_q, state_d;
  logic               modo_q, modo_d;
  logic [CYCLE_W-1:0] ciclo_q, ciclo_d;
  logic [TICK_W-1:0]  cuenta_q, cuenta_d;
  logic               fin_ciclo_q, fin_ciclo_d;
  logic               fin_total_q, fin_total_d;
  logic               activo_q, activo_d;

  logic               pausa_w;
  logic [CYCLE_W-1:0] last_w;

`ifdef CICLO_RTC_PAUSA_EN
  assign pausa_w = pausa;
`else
  assign pausa_w = 1'b0;
`endif

  // duracion=0 behaves as a single-phase sequence; substituting before the
  // subtraction keeps the last-phase index from underflowing.
  assign last_w = (duracion == '0) ? '0 : (duracion - 1'b1);

  always_comb begin
    state_d     = state_q;
    modo_d      = modo_q;
    ciclo_d     = ciclo_q;
    cuenta_d    = cuenta_q;
    fin_ciclo_d = 1'b0;
    fin_total_d = 1'b0;

    if (!EN_ciclo) begin
      // Disable wins over everything except reset, including any pulse
      // that would have been produced on this edge.
      state_d  = ST_IDLE;
      ciclo_d  = '0;
      cuenta_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_RUN;
          modo_d   = modo;
          ciclo_d  = '0;
          cuenta_d = '0;
        end
        ST_RUN: begin
          if (!pausa_w) begin
            if (cuenta_q == TICK_LAST) begin
              cuenta_d    = '0;
              fin_ciclo_d = 1'b1;
              // >= rather than == so a duracion lowered mid-run still ends.
              if (ciclo_q >= last_w) begin
                fin_total_d = 1'b1;
                if (modo_q) begin
                  state_d = ST_DONE;
                end else begin
                  ciclo_d = '0;
                end
              end else begin
                ciclo_d = ciclo_q + 1'b1;
              end
            end else begin
              cuenta_d = cuenta_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Frozen until EN_ciclo drops.
        end
        default: begin
          state_d  = ST_IDLE;
          ciclo_d  = '0;
          cuenta_d = '0;
        end
      endcase
    end

    activo_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      modo_q      <= 1'b0;
      ciclo_q     <= '0;
      cuenta_q    <= '0;
      fin_ciclo_q <= 1'b0;
      fin_total_q <= 1'b0;
      activo_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      modo_q      <= modo_d;
      ciclo_q     <= ciclo_d;
      cuenta_q    <= cuenta_d;
      fin_ciclo_q <= fin_ciclo_d;
      fin_total_q <= fin_total_d;
      activo_q    <= activo_d;
    end
  end

  assign ciclo      = ciclo_q;
  assign cuenta_int = cuenta_q;
  assign fin_ciclo  = fin_ciclo_q;
  assign fin_total  = fin_total_q;
  assign activo     = activo_q;

endmodule
